// File: rtl/hsid_pkg.sv
// Shared widths and FSM state type for the HSID MSE datapath.
package hsid_pkg;
  localparam int HSID_WORD_WIDTH        = 16;
  localparam int HSID_HSP_LIBRARY_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } hsid_mse_min_state_t;
endpackage

// File: rtl/hsid_mse_min_if.sv
// Per-reference MSE result stream; one result per mse_valid cycle, no backpressure.
interface hsid_mse_min_if
  import hsid_pkg::*;
#(
  parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
);
  logic [WORD_WIDTH-1:0]        mse_value;
  logic [HSP_LIBRARY_WIDTH-1:0] mse_ref;
  logic                         mse_valid;
  logic                         acc_of;

  modport master (output mse_value, output mse_ref, output mse_valid, output acc_of);
  modport slave  (input  mse_value, input  mse_ref, input  mse_valid, input  acc_of);
endinterface

// File: rtl/hsid_mse_cmp.sv
// Registered best-value tracker (min or max by FIND_MAX); result visible one cycle after load.
// Strict compare so ties keep the earlier entry; 'first' forces a load regardless of value.
module hsid_mse_cmp
  import hsid_pkg::*;
#(
  parameter int WORD_WIDTH = HSID_WORD_WIDTH,
  parameter int IDX_WIDTH  = HSID_HSP_LIBRARY_WIDTH,
  parameter bit FIND_MAX   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init,
  input  logic                  load,
  input  logic                  first,
  input  logic [WORD_WIDTH-1:0] value,
  input  logic [IDX_WIDTH-1:0]  idx,
  output logic [WORD_WIDTH-1:0] best_value,
  output logic [IDX_WIDTH-1:0]  best_idx
);
  localparam logic [WORD_WIDTH-1:0] INIT_VALUE = {WORD_WIDTH{~FIND_MAX}};

  logic better;

  assign better = FIND_MAX ? (value > best_value) : (value < best_value);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_value <= INIT_VALUE;
      best_idx   <= '0;
    end else if (init) begin
      best_value <= INIT_VALUE;
      best_idx   <= '0;
    end else if (load && (first || better)) begin
      best_value <= value;
      best_idx   <= idx;
    end
  end
endmodule

// File: rtl/hsid_mse_min.sv
// Best-match tracker over a run of library_size MSE results; done pulses the cycle after the last one.
// No backpressure; optional maximum tracking with HSID_MSE_MAX_TRACK_EN.
module hsid_mse_min
  import hsid_pkg::*;
#(
  parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         start,
  input  logic [HSP_LIBRARY_WIDTH-1:0] library_size,
  hsid_mse_min_if.slave                mse,
  output logic                         busy,
  output logic                         done,
  output logic [WORD_WIDTH-1:0]        min_mse_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] min_mse_ref,
  output logic                         no_match,
  output logic [HSP_LIBRARY_WIDTH-1:0] of_count,
  output logic [HSP_LIBRARY_WIDTH-1:0] rx_count
`ifdef HSID_MSE_MAX_TRACK_EN
  ,
  output logic [WORD_WIDTH-1:0]        max_mse_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] max_mse_ref
`endif
);
  localparam logic [HSP_LIBRARY_WIDTH-1:0] ONE = HSP_LIBRARY_WIDTH'(1);

  hsid_mse_min_state_t          state;
  logic [HSP_LIBRARY_WIDTH-1:0] lib_size;
  logic                         run_init;
  logic                         good;

  // Trackers reinitialise on clear and on any accepted start, zero-size runs included.
  assign run_init = clear | ((state == IDLE) & start);
  assign good     = (state == RUN) & mse.mse_valid & ~mse.acc_of & ~clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      lib_size <= '0;
      rx_count <= '0;
      of_count <= '0;
      no_match <= 1'b1;
    end else if (clear) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      lib_size <= '0;
      rx_count <= '0;
      of_count <= '0;
      no_match <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lib_size <= library_size;
            rx_count <= '0;
            of_count <= '0;
            no_match <= 1'b1;
            if (library_size != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (mse.mse_valid) begin
            rx_count <= rx_count + ONE;
            if (mse.acc_of) of_count <= of_count + ONE;
            else            no_match <= 1'b0;
            if (rx_count == lib_size - ONE) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  hsid_mse_cmp #(
    .WORD_WIDTH (WORD_WIDTH),
    .IDX_WIDTH  (HSP_LIBRARY_WIDTH),
    .FIND_MAX   (1'b0)
  ) u_min (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (run_init),
    .load       (good),
    .first      (no_match),
    .value      (mse.mse_value),
    .idx        (mse.mse_ref),
    .best_value (min_mse_value),
    .best_idx   (min_mse_ref)
  );

`ifdef HSID_MSE_MAX_TRACK_EN
  hsid_mse_cmp #(
    .WORD_WIDTH (WORD_WIDTH),
    .IDX_WIDTH  (HSP_LIBRARY_WIDTH),
    .FIND_MAX   (1'b1)
  ) u_max (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (run_init),
    .load       (good),
    .first      (no_match),
    .value      (mse.mse_value),
    .idx        (mse.mse_ref),
    .best_value (max_mse_value),
    .best_idx   (max_mse_ref)
  );
`endif
endmodule

// File: tb/tb_hsid_mse_min.sv
// Bench for hsid_mse_min: directed cases with literal expectations plus randomized runs vs a queue model.
module tb_hsid_mse_min;
  import hsid_pkg::*;

  localparam int W = HSID_WORD_WIDTH;
  localparam int L = HSID_HSP_LIBRARY_WIDTH;
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic [L-1:0] library_size = '0;
  logic         busy, done, no_match;
  logic [W-1:0] min_mse_value;
  logic [L-1:0] min_mse_ref, of_count, rx_count;
`ifdef HSID_MSE_MAX_TRACK_EN
  logic [W-1:0] max_mse_value;
  logic [L-1:0] max_mse_ref;
`endif

  hsid_mse_min_if #(.WORD_WIDTH(W), .HSP_LIBRARY_WIDTH(L)) mse ();

  hsid_mse_min #(.WORD_WIDTH(W), .HSP_LIBRARY_WIDTH(L)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .start         (start),
    .library_size  (library_size),
    .mse           (mse.slave),
    .busy          (busy),
    .done          (done),
    .min_mse_value (min_mse_value),
    .min_mse_ref   (min_mse_ref),
    .no_match      (no_match),
    .of_count      (of_count),
    .rx_count      (rx_count)
`ifdef HSID_MSE_MAX_TRACK_EN
    ,
    .max_mse_value (max_mse_value),
    .max_mse_ref   (max_mse_ref)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: the run is just the list of results accepted so far.
  logic [W-1:0] q_val[$];
  logic [L-1:0] q_ref[$];
  bit           q_of[$];
  int           m_phase = 0;  // 0 idle, 1 collecting, 2 reporting
  int           m_size  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      q_val.delete(); q_ref.delete(); q_of.delete();
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        q_val.delete(); q_ref.delete(); q_of.delete();
        m_size  = int'(library_size);
        m_phase = (m_size > 0) ? 1 : 2;
      end
    end else if (m_phase == 1) begin
      if (mse.mse_valid) begin
        q_val.push_back(mse.mse_value);
        q_ref.push_back(mse.mse_ref);
        q_of.push_back(mse.acc_of);
        if (q_val.size() == m_size) m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] emin, emax;
    logic [L-1:0] eref, exref;
    int nof, ngood;
    bit fmin, fmax;
    if (chk_en) begin
      nof = 0; ngood = 0; emin = ALL_ONES; emax = '0; eref = '0; exref = '0;
      fmin = 1'b0; fmax = 1'b0;
      foreach (q_val[i]) begin
        if (q_of[i]) nof++;
        else begin
          ngood++;
          if (q_val[i] < emin) emin = q_val[i];
          if (q_val[i] > emax) emax = q_val[i];
        end
      end
      foreach (q_val[i]) begin
        if (!q_of[i] && !fmin && q_val[i] == emin) begin eref = q_ref[i]; fmin = 1'b1; end
        if (!q_of[i] && !fmax && q_val[i] == emax) begin exref = q_ref[i]; fmax = 1'b1; end
      end
      chk("m_busy", 32'(busy), 32'(m_phase == 1));
      chk("m_done", 32'(done), 32'(m_phase == 2));
      chk("m_min", 32'(min_mse_value), 32'(emin));
      chk("m_min_ref", 32'(min_mse_ref), 32'(eref));
      chk("m_no_match", 32'(no_match), 32'(ngood == 0));
      chk("m_of_count", 32'(of_count), 32'(nof));
      chk("m_rx_count", 32'(rx_count), 32'(q_val.size()));
`ifdef HSID_MSE_MAX_TRACK_EN
      chk("m_max", 32'(max_mse_value), 32'(emax));
      chk("m_max_ref", 32'(max_mse_ref), 32'(exref));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int sz);
    start = 1'b1;
    library_size = L'(sz);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int r, input int v, input bit of);
    mse.mse_valid = 1'b1;
    mse.mse_ref   = L'(r);
    mse.mse_value = W'(v);
    mse.acc_of    = of;
    tick();
    mse.mse_valid = 1'b0;
    mse.acc_of    = 1'b0;
  endtask

  initial begin
    int sz;
    mse.mse_valid = 1'b0;
    mse.mse_value = '0;
    mse.mse_ref   = '0;
    mse.acc_of    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_min", 32'(min_mse_value), 32'(ALL_ONES));
    chk("rst_min_ref", 32'(min_mse_ref), 0);
    chk("rst_no_match", 32'(no_match), 1);
    chk("rst_of", 32'(of_count), 0);
    chk("rst_rx", 32'(rx_count), 0);
    chk_en = 1'b1;

    // Nominal run with a tie at value 20.
    do_start(4);
    chk("nom_busy", 32'(busy), 1);
    send(0, 50, 0); send(1, 20, 0); send(2, 20, 0); send(3, 90, 0);
    chk("nom_done", 32'(done), 1);
    chk("nom_busy_end", 32'(busy), 0);
    chk("nom_min", 32'(min_mse_value), 20);
    chk("nom_ref", 32'(min_mse_ref), 1);
    chk("nom_no_match", 32'(no_match), 0);
    chk("nom_of", 32'(of_count), 0);
`ifdef HSID_MSE_MAX_TRACK_EN
    chk("nom_max", 32'(max_mse_value), 90);
    chk("nom_max_ref", 32'(max_mse_ref), 3);
`endif
    tick();
    chk("nom_done_pulse", 32'(done), 0);

    do_start(3);
    send(0, 5, 1); send(1, 40, 0); send(2, 30, 0);
    chk("of_done", 32'(done), 1);
    chk("of_min", 32'(min_mse_value), 30);
    chk("of_ref", 32'(min_mse_ref), 2);
    chk("of_count", 32'(of_count), 1);
    tick();

    do_start(2);
    send(0, 3, 1); send(1, 4, 1);
    chk("allof_done", 32'(done), 1);
    chk("allof_no_match", 32'(no_match), 1);
    chk("allof_min", 32'(min_mse_value), 32'(ALL_ONES));
    chk("allof_of", 32'(of_count), 2);
    tick();

    do_start(0);
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_no_match", 32'(no_match), 1);
    tick();
    chk("zero_done_pulse", 32'(done), 0);
    chk("zero_busy2", 32'(busy), 0);

    // An all-ones MSE is still a real match.
    do_start(1);
    send(9, int'(ALL_ONES), 0);
    chk("ones_no_match", 32'(no_match), 0);
    chk("ones_ref", 32'(min_mse_ref), 9);
    tick();

    do_start(5);
    send(0, 11, 0); send(1, 12, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", 32'(busy), 0);
    chk("clr_done", 32'(done), 0);
    chk("clr_min", 32'(min_mse_value), 32'(ALL_ONES));
    chk("clr_rx", 32'(rx_count), 0);
    chk("clr_no_match", 32'(no_match), 1);
    do_start(1);
    send(3, 7, 0);
    chk("clr_new_done", 32'(done), 1);
    chk("clr_new_min", 32'(min_mse_value), 7);
    chk("clr_new_ref", 32'(min_mse_ref), 3);
    tick();

    send(5, 1, 0);
    chk("idle_min", 32'(min_mse_value), 7);
    chk("idle_rx", 32'(rx_count), 1);

    do_start(3);
    send(0, 9, 0);
    start = 1'b1;
    library_size = L'(1);
    send(1, 8, 0);
    start = 1'b0;
    chk("rs_busy", 32'(busy), 1);
    chk("rs_rx", 32'(rx_count), 2);
    send(2, 10, 0);
    chk("rs_done", 32'(done), 1);
    chk("rs_min", 32'(min_mse_value), 8);
    chk("rs_ref", 32'(min_mse_ref), 1);
    tick();

    for (int r = 0; r < 120; r++) begin
      if ($urandom_range(0, 3) == 0) send($urandom_range(0, 255), $urandom_range(0, 20), 1'b0);
      sz = $urandom_range(0, 9);
      do_start(sz);
      for (int c = 0; c < 40; c++) begin
        if (!busy) break;
        mse.mse_valid = ($urandom_range(0, 3) != 0);
        mse.mse_ref   = L'($urandom_range(0, 255));
        case ($urandom_range(0, 5))
          0:       mse.mse_value = ALL_ONES;
          1:       mse.mse_value = W'($urandom);
          default: mse.mse_value = W'($urandom_range(0, 12));
        endcase
        mse.acc_of   = ($urandom_range(0, 4) == 0);
        start        = ($urandom_range(0, 9) == 0);
        library_size = L'($urandom_range(0, 9));
        clear        = ($urandom_range(0, 60) == 0);
        tick();
      end
      mse.mse_valid = 1'b0;
      mse.acc_of    = 1'b0;
      start         = 1'b0;
      clear         = 1'b0;
      if (busy) begin
        chk("rand_run_timeout", 32'(busy), 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
      end
      tick();
      tick();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
